alu_unit: RTL and testbench

Parameterised, registered integer ALU with arithmetic and logical command sets selected by MODE, and operand-validity qualification via INP_VALID. One result register plus status flags (carry, overflow, error, compare). Sits in the datapath as a single-issue execution unit; a new command may be presented every clock.

---
 rtl/alu_unit.sv | 201 ++++++++++++++++++++
 tb/tb_alu_unit.sv | 123 ++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// Registered integer ALU: arithmetic (MODE=1) and logical (MODE=0) command sets, one result + status flags.
// Optional: define ALU_MULT_2CYC_EN to give the two multiply commands a 2-cycle latency.
module alu_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int CMD_WIDTH  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CE,
    input  logic [1:0]              INP_VALID,
    input  logic                    MODE,
    input  logic [CMD_WIDTH-1:0]    CMD,
    input  logic [DATA_WIDTH-1:0]   OPA,
    input  logic [DATA_WIDTH-1:0]   OPB,
    input  logic                    CIN,
    output logic [2*DATA_WIDTH-1:0] RES,
    output logic                    ERR,
    output logic                    OFLOW,
    output logic                    COUT,
    output logic                    G,
    output logic                    L,
    output logic                    E
);
    localparam int W    = DATA_WIDTH;
    localparam int SH_W = $clog2(W);

    typedef struct packed {
        logic [2*W-1:0] res;
        logic           err;
        logic           oflow;
        logic           cout;
        logic           g;
        logic           l;
        logic           e;
    } alu_rsp_t;

    alu_rsp_t    op_rsp, rsp_n, rsp_q;
    logic [1:0]  need;
    logic        bad_cmd, fault;
    int unsigned cmd_i;

    function automatic logic [2*W-1:0] zx(input logic [W-1:0] v);
        return {{W{1'b0}}, v};
    endfunction

    function automatic logic [2*W-1:0] zx1(input logic [W:0] v);
        return {{(W-1){1'b0}}, v};
    endfunction

    function automatic logic [2*W-1:0] sx1(input logic [W:0] v);
        return {{(W-1){v[W]}}, v};
    endfunction

    // W+1 bit operands so carry/borrow falls out in the top bit
    logic [W:0]       a_x, b_x, one_x, cin_x;
    logic [W:0]       sum, sum_c, diff, diff_c, inc_a, dec_a, inc_b, dec_b;
    logic [W:0]       ssum, sdiff;
    logic [2*W-1:0]   prod_inc, prod_shl, rol_t, ror_t;
    logic             rot_err;

    assign a_x      = {1'b0, OPA};
    assign b_x      = {1'b0, OPB};
    assign one_x    = {{W{1'b0}}, 1'b1};
    assign cin_x    = {{W{1'b0}}, CIN};
    assign sum      = a_x + b_x;
    assign sum_c    = a_x + b_x + cin_x;
    assign diff     = a_x - b_x;
    assign diff_c   = a_x - b_x - cin_x;
    assign inc_a    = a_x + one_x;
    assign dec_a    = a_x - one_x;
    assign inc_b    = b_x + one_x;
    assign dec_b    = b_x - one_x;
    assign ssum     = {OPA[W-1], OPA} + {OPB[W-1], OPB};
    assign sdiff    = {OPA[W-1], OPA} - {OPB[W-1], OPB};
    assign prod_inc = zx1(inc_a) * zx1(inc_b);
    assign prod_shl = zx1({OPA, 1'b0}) * zx(OPB);
    assign rol_t    = {OPA, OPA} << OPB[SH_W-1:0];
    assign ror_t    = {OPA, OPA} >> OPB[SH_W-1:0];
    assign rot_err  = |OPB[W-1:SH_W];
    assign cmd_i    = 32'(CMD);

    // Which operands each command consumes; unlisted commands are illegal
    always_comb begin
        need    = 2'b11;
        bad_cmd = 1'b0;
        if (MODE) begin
            case (cmd_i)
                0, 1, 2, 3, 8, 9, 10, 11, 12: need = 2'b11;
                4, 5:                         need = 2'b01;
                6, 7:                         need = 2'b10;
                default:                      bad_cmd = 1'b1;
            endcase
        end else begin
            case (cmd_i)
                0, 1, 2, 3, 4, 5, 12, 13: need = 2'b11;
                6, 8, 9:                  need = 2'b01;
                7, 10, 11:                need = 2'b10;
                default:                  bad_cmd = 1'b1;
            endcase
        end
        fault = bad_cmd || ((need & ~INP_VALID) != 2'b00);
    end

    always_comb begin
        op_rsp = '0;
        if (MODE) begin
            case (cmd_i)
                0:  begin op_rsp.res = zx1(sum);   op_rsp.cout = sum[W];   end
                1:  begin op_rsp.res = zx(diff[W-1:0]);   op_rsp.oflow = diff[W];   end
                2:  begin op_rsp.res = zx1(sum_c); op_rsp.cout = sum_c[W]; end
                3:  begin op_rsp.res = zx(diff_c[W-1:0]); op_rsp.oflow = diff_c[W]; end
                4:  begin op_rsp.res = zx1(inc_a); op_rsp.cout = inc_a[W]; end
                5:  begin op_rsp.res = zx(dec_a[W-1:0]);  op_rsp.oflow = dec_a[W];  end
                6:  begin op_rsp.res = zx1(inc_b); op_rsp.cout = inc_b[W]; end
                7:  begin op_rsp.res = zx(dec_b[W-1:0]);  op_rsp.oflow = dec_b[W];  end
                8:  begin
                    op_rsp.g = OPA > OPB;
                    op_rsp.l = OPA < OPB;
                    op_rsp.e = OPA == OPB;
                end
                9:  op_rsp.res = prod_inc;
                10: op_rsp.res = prod_shl;
                11, 12: begin
                    // Overflow when the W+1 bit exact result's top two bits disagree
                    op_rsp.res   = (cmd_i == 11) ? sx1(ssum) : sx1(sdiff);
                    op_rsp.oflow = (cmd_i == 11) ? (ssum[W] ^ ssum[W-1]) : (sdiff[W] ^ sdiff[W-1]);
                    op_rsp.g     = $signed(OPA) > $signed(OPB);
                    op_rsp.l     = $signed(OPA) < $signed(OPB);
                    op_rsp.e     = OPA == OPB;
                end
                default: ;
            endcase
        end else begin
            case (cmd_i)
                0:  op_rsp.res = zx(OPA & OPB);
                1:  op_rsp.res = zx(~(OPA & OPB));
                2:  op_rsp.res = zx(OPA | OPB);
                3:  op_rsp.res = zx(~(OPA | OPB));
                4:  op_rsp.res = zx(OPA ^ OPB);
                5:  op_rsp.res = zx(~(OPA ^ OPB));
                6:  op_rsp.res = zx(~OPA);
                7:  op_rsp.res = zx(~OPB);
                8:  op_rsp.res = zx(OPA >> 1);
                9:  op_rsp.res = zx(OPA << 1);
                10: op_rsp.res = zx(OPB >> 1);
                11: op_rsp.res = zx(OPB << 1);
                12: begin op_rsp.res = zx(rol_t[2*W-1:W]); op_rsp.err = rot_err; end
                13: begin op_rsp.res = zx(ror_t[W-1:0]);   op_rsp.err = rot_err; end
                default: ;
            endcase
        end
    end

    always_comb begin
        rsp_n = op_rsp;
        if (fault) begin
            rsp_n     = '0;
            rsp_n.err = 1'b1;
        end
    end

`ifdef ALU_MULT_2CYC_EN
    logic     mul_pend;
    alu_rsp_t mul_q;
    logic     is_mul;

    assign is_mul = MODE && (cmd_i == 9 || cmd_i == 10) && !fault;

    // First edge parks the product; the next CE edge publishes it and ignores its inputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rsp_q    <= '0;
            mul_q    <= '0;
            mul_pend <= 1'b0;
        end else if (CE) begin
            if (mul_pend) begin
                rsp_q    <= mul_q;
                mul_pend <= 1'b0;
            end else if (is_mul) begin
                mul_q    <= rsp_n;
                mul_pend <= 1'b1;
            end else begin
                rsp_q    <= rsp_n;
            end
        end
    end
`else
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)    rsp_q <= '0;
        else if (CE) rsp_q <= rsp_n;
    end
`endif

    assign RES   = rsp_q.res;
    assign ERR   = rsp_q.err;
    assign OFLOW = rsp_q.oflow;
    assign COUT  = rsp_q.cout;
    assign G     = rsp_q.g;
    assign L     = rsp_q.l;
    assign E     = rsp_q.e;
endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit (8-bit); expected values are hand-computed.
module tb_alu_unit;
    logic        CLK = 1'b0;
    logic        RST, CE, MODE, CIN;
    logic [1:0]  INP_VALID;
    logic [3:0]  CMD;
    logic [7:0]  OPA, OPB;
    logic [15:0] RES;
    logic        ERR, OFLOW, COUT, G, L, E;
    logic [5:0]  flg;

    int checks = 0;
    int fails  = 0;

    alu_unit #(.DATA_WIDTH(8), .CMD_WIDTH(4)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .INP_VALID(INP_VALID), .MODE(MODE),
        .CMD(CMD), .OPA(OPA), .OPB(OPB), .CIN(CIN),
        .RES(RES), .ERR(ERR), .OFLOW(OFLOW), .COUT(COUT), .G(G), .L(L), .E(E)
    );

    always #5 CLK = ~CLK;
    assign flg = {ERR, OFLOW, COUT, G, L, E};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic m, input int c, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic [1:0] iv);
        MODE = m; CMD = 4'(c); OPA = a; OPB = b; CIN = ci; INP_VALID = iv;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // flags order: {ERR,OFLOW,COUT,G,L,E}
    task automatic vec(input string tag, input logic m, input int c, input logic [7:0] a,
                       input logic [7:0] b, input logic ci, input logic [1:0] iv,
                       input logic [15:0] eres, input logic [5:0] eflg);
        drv(m, c, a, b, ci, iv);
        step();
`ifdef ALU_MULT_2CYC_EN
        if (m && (c == 9 || c == 10) && iv == 2'b11) step();
`endif
        chk({tag, ".res"}, 32'(RES), 32'(eres));
        chk({tag, ".flg"}, 32'(flg), 32'(eflg));
    endtask

    initial begin
        RST = 1'b0; CE = 1'b1;
        drv(1'b1, 0, 8'd217, 8'd117, 1'b1, 2'b11);
        #3;
        chk("rst_async.res", 32'(RES), 32'd0);
        chk("rst_async.flg", 32'(flg), 32'd0);
        step(); step();
        chk("rst_hold.res", 32'(RES), 32'd0);
        RST = 1'b1;
        #2;
        chk("rst_rel.res", 32'(RES), 32'd0);
        chk("rst_rel.flg", 32'(flg), 32'd0);
        step();
        chk("add.res", 32'(RES), 32'd334);
        chk("add.flg", 32'(flg), 32'b001000);

        // CE low across a command change: outputs hold
        CE = 1'b0;
        drv(1'b1, 1, 8'd217, 8'd117, 1'b1, 2'b11);
        step(); step();
        chk("ce_hold.res", 32'(RES), 32'd334);
        chk("ce_hold.flg", 32'(flg), 32'b001000);
        CE = 1'b1;

        vec("sub",     1'b1, 1,  8'd217, 8'd117, 1'b1, 2'b11, 16'd100,   6'b000000);
        vec("add_cin", 1'b1, 2,  8'd217, 8'd117, 1'b1, 2'b11, 16'd335,   6'b001000);
        vec("sub_cin", 1'b1, 3,  8'd217, 8'd117, 1'b1, 2'b11, 16'd99,    6'b000000);
        vec("sub_brw", 1'b1, 1,  8'd5,   8'd7,   1'b0, 2'b11, 16'd254,   6'b010000);
        vec("cmp_gt",  1'b1, 8,  8'd217, 8'd117, 1'b1, 2'b11, 16'd0,     6'b000100);
        vec("cmp_eq",  1'b1, 8,  8'd42,  8'd42,  1'b0, 2'b11, 16'd0,     6'b000001);
        vec("mul_inc", 1'b1, 9,  8'd217, 8'd117, 1'b1, 2'b11, 16'd25724, 6'b000000);
        vec("mul_shl", 1'b1, 10, 8'd217, 8'd117, 1'b1, 2'b11, 16'd50778, 6'b000000);
        vec("sadd_ov", 1'b1, 11, 8'd120, 8'd120, 1'b0, 2'b11, 16'd240,   6'b010001);
        vec("sadd_ng", 1'b1, 11, 8'h9E,  8'd15,  1'b0, 2'b11, 16'hFFAD,  6'b000010);
        vec("ssub_ov", 1'b1, 12, 8'd100, 8'h88,  1'b0, 2'b11, 16'd220,   6'b010100);
        vec("inc_a",   1'b1, 4,  8'd5,   8'd0,   1'b0, 2'b01, 16'd6,     6'b000000);
        vec("inc_a_c", 1'b1, 4,  8'd255, 8'd0,   1'b0, 2'b01, 16'd256,   6'b001000);
        vec("dec_a_w", 1'b1, 5,  8'd0,   8'd0,   1'b0, 2'b01, 16'd255,   6'b010000);
        vec("dec_b",   1'b1, 7,  8'd0,   8'd9,   1'b0, 2'b10, 16'd8,     6'b000000);
        vec("add_iv1", 1'b1, 0,  8'd217, 8'd117, 1'b1, 2'b01, 16'd0,     6'b100000);
        vec("inc_b_iv",1'b1, 6,  8'd1,   8'd2,   1'b0, 2'b01, 16'd0,     6'b100000);
        vec("bad_cmd", 1'b1, 14, 8'd217, 8'd117, 1'b1, 2'b11, 16'd0,     6'b100000);

        vec("and",     1'b0, 0,  8'd217, 8'd117, 1'b0, 2'b11, 16'd81,    6'b000000);
        vec("xor",     1'b0, 4,  8'd217, 8'd117, 1'b0, 2'b11, 16'd172,   6'b000000);
        vec("nor",     1'b0, 3,  8'd217, 8'd117, 1'b0, 2'b11, 16'd2,     6'b000000);
        vec("not_a",   1'b0, 6,  8'd217, 8'd117, 1'b0, 2'b01, 16'd38,    6'b000000);
        vec("shl_a",   1'b0, 9,  8'd217, 8'd117, 1'b0, 2'b01, 16'd178,   6'b000000);
        vec("shr_b",   1'b0, 10, 8'd217, 8'd117, 1'b0, 2'b10, 16'd58,    6'b000000);
        vec("rol",     1'b0, 12, 8'd15,  8'd3,   1'b0, 2'b11, 16'd120,   6'b000000);
        vec("ror",     1'b0, 13, 8'd15,  8'd3,   1'b0, 2'b11, 16'hE1,    6'b000000);
        vec("rol_err", 1'b0, 12, 8'd15,  8'h13,  1'b0, 2'b11, 16'd120,   6'b100000);
        vec("and_iv0", 1'b0, 0,  8'd217, 8'd117, 1'b0, 2'b00, 16'd0,     6'b100000);
        vec("lbad",    1'b0, 15, 8'd217, 8'd117, 1'b0, 2'b11, 16'd0,     6'b100000);

        // Reset mid-cycle discards the held result immediately
        vec("pre_rst", 1'b1, 0,  8'd217, 8'd117, 1'b0, 2'b11, 16'd334,   6'b001000);
        #2 RST = 1'b0;
        #1;
        chk("rst_mid.res", 32'(RES), 32'd0);
        chk("rst_mid.flg", 32'(flg), 32'd0);
        RST = 1'b1;
        step();
        chk("post_rst.res", 32'(RES), 32'd334);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
